// File: rtl/imem_boot_loader.sv
// Boot-time instruction loader: streams words into instruction memory at
// consecutive addresses, then holds the core in reset for one cycle with the start PC.
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [31:0]       load_addr,
  input  logic [ADDR_W:0]   load_count,
  input  logic [31:0]       start_pc,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [31:0]       pc_init,
  output logic              core_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam logic [32:0]     CAP_WORDS = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t state_r, state_nxt_s;

  logic            s_ready_r,  s_ready_nxt_s;
  logic            imem_we_r,  imem_we_nxt_s;
  logic [31:0]     imem_addr_r, imem_addr_nxt_s;
  logic [31:0]     imem_wdata_r, imem_wdata_nxt_s;
  logic [31:0]     pc_init_r,  pc_init_nxt_s;
  logic            core_run_r, core_run_nxt_s;
  logic            busy_r,     busy_nxt_s;
  logic            done_r,     done_nxt_s;
  logic            err_r,      err_nxt_s;
  logic [31:0]     addr_r,     addr_nxt_s;
  logic [ADDR_W:0] cnt_r,      cnt_nxt_s;
  logic [31:0]     pc_lat_r,   pc_lat_nxt_s;

  logic [32:0]     count_ext_s;
  logic [32:0]     end_idx_s;
  logic            req_ok_s;
  logic            hs_s;
  logic            last_s;

  // End word index is formed at 33 bits so an out-of-range request can never wrap into range.
  assign count_ext_s = {{(32-ADDR_W){1'b0}}, load_count};
  assign end_idx_s   = {3'b000, load_addr[31:2]} + count_ext_s;
  assign req_ok_s    = (count_ext_s != 33'd0) && (count_ext_s <= CAP_WORDS) &&
                       (load_addr[1:0] == 2'b00) && (start_pc[1:0] == 2'b00) &&
                       (end_idx_s <= CAP_WORDS);
  assign hs_s        = s_valid && s_ready_r;
  assign last_s      = (cnt_r == CNT_ONE);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (load_start && req_ok_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LOAD: begin
        if (hs_s && last_s) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_RELEASE: state_nxt_s = ST_RUN;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and the session datapath.
  always_comb begin
    s_ready_nxt_s    = s_ready_r;
    imem_we_nxt_s    = 1'b0;
    imem_addr_nxt_s  = imem_addr_r;
    imem_wdata_nxt_s = imem_wdata_r;
    pc_init_nxt_s    = pc_init_r;
    core_run_nxt_s   = core_run_r;
    busy_nxt_s       = busy_r;
    done_nxt_s       = done_r;
    err_nxt_s        = err_r;
    addr_nxt_s       = addr_r;
    cnt_nxt_s        = cnt_r;
    pc_lat_nxt_s     = pc_lat_r;
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (load_start) begin
          if (req_ok_s) begin
            addr_nxt_s     = load_addr;
            cnt_nxt_s      = load_count;
            pc_lat_nxt_s   = start_pc;
            err_nxt_s      = 1'b0;
            done_nxt_s     = 1'b0;
            core_run_nxt_s = 1'b0;
            busy_nxt_s     = 1'b1;
            s_ready_nxt_s  = 1'b1;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          err_nxt_s = err_r;
        end
      end
      ST_LOAD: begin
        if (hs_s) begin
          imem_we_nxt_s    = 1'b1;
          imem_addr_nxt_s  = addr_r;
          imem_wdata_nxt_s = s_data;
          addr_nxt_s       = addr_r + 32'd4;
          cnt_nxt_s        = cnt_r - CNT_ONE;
          if (last_s) begin
            s_ready_nxt_s = 1'b0;
            pc_init_nxt_s = pc_lat_r;
          end else begin
            s_ready_nxt_s = 1'b1;
          end
        end else begin
          imem_we_nxt_s = 1'b0;
        end
      end
      ST_RELEASE: begin
        core_run_nxt_s = 1'b1;
        done_nxt_s     = 1'b1;
        busy_nxt_s     = 1'b0;
        s_ready_nxt_s  = 1'b0;
      end
      default: begin
        s_ready_nxt_s  = 1'b0;
        core_run_nxt_s = 1'b0;
        busy_nxt_s     = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_ready_r    <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= 32'd0;
      imem_wdata_r <= 32'd0;
      pc_init_r    <= 32'd0;
      core_run_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      addr_r       <= 32'd0;
      cnt_r        <= {(ADDR_W+1){1'b0}};
      pc_lat_r     <= 32'd0;
    end else begin
      s_ready_r    <= s_ready_nxt_s;
      imem_we_r    <= imem_we_nxt_s;
      imem_addr_r  <= imem_addr_nxt_s;
      imem_wdata_r <= imem_wdata_nxt_s;
      pc_init_r    <= pc_init_nxt_s;
      core_run_r   <= core_run_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      err_r        <= err_nxt_s;
      addr_r       <= addr_nxt_s;
      cnt_r        <= cnt_nxt_s;
      pc_lat_r     <= pc_lat_nxt_s;
    end
  end

  assign s_ready    = s_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign pc_init    = pc_init_r;
  assign core_run   = core_run_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed scenarios plus randomized
// requests judged by a transaction-level model of the acceptance and write rules.
module tb_imem_boot_loader;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic [31:0] load_addr;
  logic [8:0]  load_count;
  logic [31:0] start_pc;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] pc_init;
  logic        core_run;
  logic        busy;
  logic        done;
  logic        err;

  int checks_r;
  int failures_r;
  int we_pulses_r;
  bit running_s;

  imem_boot_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_addr(load_addr),
    .load_count(load_count), .start_pc(start_pc), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .pc_init(pc_init), .core_run(core_run), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts write strobes seen at clock edges.
  always @(posedge clk) begin
    if (imem_we === 1'b1) we_pulses_r <= we_pulses_r + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      failures_r++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit req_ok(input logic [31:0] a, input int n, input logic [31:0] pc);
    longint widx;
    widx = longint'(a >> 2) + longint'(n);
    return (n >= 1) && (n <= 256) && (a % 4 == 0) && (pc % 4 == 0) && (widx <= 256);
  endfunction

  // mode 0: s_valid always 1; mode 1: random s_valid; mode 2: fixed stall pattern.
  task automatic run_session(input logic [31:0] a, input int n, input logic [31:0] pc,
                             input int mode, input bit inject);
    int got, cyc, edges;
    bit hs;
    logic [31:0] d;
    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    load_addr  = a;
    load_count = 9'(n);
    start_pc   = pc;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    edges = 1;
    running_s = 1'b0;
    check_val("start_s_ready", 32'(s_ready), 32'd1);
    check_val("start_busy", 32'(busy), 32'd1);
    check_val("start_core_run", 32'(core_run), 32'd0);
    check_val("start_err", 32'(err), 32'd0);
    check_val("start_done", 32'(done), 32'd0);
    got = 0;
    cyc = 0;
    while (got < n && cyc < n * 8 + 64) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = 1'($urandom_range(0, 1));
        default: s_valid = pat[cyc % 7];
      endcase
      s_data = $urandom;
      if (inject && cyc == 1) begin
        load_count = 9'd0;
        load_start = 1'b1;
      end
      hs = s_valid;
      d  = s_data;
      check_val("load_s_ready", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
      edges++;
      cyc++;
      load_start = 1'b0;
      s_valid    = 1'b0;
      check_val("we_follows_hs", 32'(imem_we), 32'(hs));
      if (hs) begin
        check_val("wr_addr", imem_addr, a + 32'(4 * got));
        check_val("wr_data", imem_wdata, d);
        got++;
      end
    end
    if (got < n) check_val("load_timeout", 32'(got), 32'(n));
    check_val("rel_s_ready", 32'(s_ready), 32'd0);
    check_val("rel_busy", 32'(busy), 32'd1);
    check_val("rel_core_run", 32'(core_run), 32'd0);
    check_val("rel_pc_init", pc_init, pc);
    check_val("rel_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    edges++;
    check_val("run_core_run", 32'(core_run), 32'd1);
    check_val("run_done", 32'(done), 32'd1);
    check_val("run_busy", 32'(busy), 32'd0);
    check_val("run_we", 32'(imem_we), 32'd0);
    check_val("run_pc_init", pc_init, pc);
    if (mode == 0) check_val("edges_to_run", 32'(edges), 32'(n + 2));
    running_s = 1'b1;
  endtask

  task automatic try_reject(input logic [31:0] a, input int n, input logic [31:0] pc,
                            input string tag);
    load_addr  = a;
    load_count = 9'(n);
    start_pc   = pc;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    check_val(tag, 32'(err), 32'd1);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check_val({tag, "_core_run"}, 32'(core_run), 32'(running_s));
    check_val({tag, "_done"}, 32'(done), 32'(running_s));
  endtask

  initial begin
    int base, p1;
    logic [31:0] ra, rpc;
    int rn;
    checks_r = 0;
    failures_r = 0;
    we_pulses_r = 0;
    running_s = 1'b0;
    rst = 1'b0;
    load_start = 1'b0;
    load_addr = 32'd0;
    load_count = 9'd0;
    start_pc = 32'd0;
    s_valid = 1'b0;
    s_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_s_ready", 32'(s_ready), 32'd0);
    check_val("rst_we", 32'(imem_we), 32'd0);
    check_val("rst_addr", imem_addr, 32'd0);
    check_val("rst_wdata", imem_wdata, 32'd0);
    check_val("rst_pc_init", pc_init, 32'd0);
    check_val("rst_core_run", 32'(core_run), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    try_reject(32'd200, 0, 32'd0, "rej_count0");
    run_session(32'd200, 4, 32'd212, 0, 1'b0);
    try_reject(32'd6, 2, 32'd0, "rej_misaligned");
    try_reject(32'd1020, 2, 32'd0, "rej_overflow");
    run_session(32'd40, 4, 32'd44, 2, 1'b0);
    run_session(32'd0, 256, 32'd0, 0, 1'b0);
    run_session(32'd100, 6, 32'd0, 1, 1'b1);

    for (int i = 0; i < 24; i++) begin
      ra  = 32'($urandom_range(0, 270)) << 2;
      if ($urandom_range(0, 5) == 0) ra = ra | 32'($urandom_range(1, 3));
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) rpc = rpc | 32'd2;
      rn  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(257, 300)) : int'($urandom_range(0, 20));
      if (req_ok(ra, rn, rpc)) run_session(ra, rn, rpc, 1, 1'b0);
      else try_reject(ra, rn, rpc, "rej_random");
    end

    base = we_pulses_r;
    load_addr  = 32'd0;
    load_count = 9'd4;
    start_pc   = 32'd0;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    repeat (2) begin
      s_valid = 1'b1;
      s_data  = $urandom;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    running_s = 1'b0;
    check_val("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check_val("mid_rst_we", 32'(imem_we), 32'd0);
    check_val("mid_rst_addr", imem_addr, 32'd0);
    check_val("mid_rst_wdata", imem_wdata, 32'd0);
    check_val("mid_rst_pc_init", pc_init, 32'd0);
    check_val("mid_rst_core_run", 32'(core_run), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_done", 32'(done), 32'd0);
    check_val("mid_rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    p1 = we_pulses_r;
    check_val("mid_rst_writes", 32'(p1 - base), 32'd2);
    s_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    s_valid = 1'b0;
    check_val("post_rst_no_we", 32'(we_pulses_r), 32'(p1));
    check_val("post_rst_core_run", 32'(core_run), 32'd0);
    check_val("post_rst_s_ready", 32'(s_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
